// File: rtl/escalonador_interfaces.sv
// ---------------------------------------------------------------------------
// escalonador_interfaces
//   Arbitrates a shared display/matrix resource between two requesting
//   interfaces. A grant opens an execution window of TEMPO_EXEC cycles,
//   counting the ack cycle. A strictly higher-profile request from the other
//   interface preempts the window. Every window ends with a one-cycle release
//   phase that pulses fim.
//
// Ports
//   clk                 clock, rising edge
//   rst                 asynchronous reset, active high
//   req0/req1           request level per interface
//   perfil0/perfil1     requester profile (1..5 valid)
//   funcao0/funcao1     requested function (non-zero valid)
//   ack0/ack1           one-cycle grant pulse
//   rej0/rej1           one-cycle rejection pulse
//   ocupado             resource in use
//   dono                owner: 00 none, 01 interface 0, 10 interface 1
//   perfil_ativo        latched profile of the owner
//   func_ativa          latched function of the owner
//   fim                 one-cycle end-of-window pulse
//   preempcao           one-cycle pulse marking a preempted window
// ---------------------------------------------------------------------------
module escalonador_interfaces #(
    parameter int TEMPO_EXEC = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [2:0] perfil0,
    input  logic [2:0] perfil1,
    input  logic [2:0] funcao0,
    input  logic [2:0] funcao1,
    output logic       ack0,
    output logic       ack1,
    output logic       rej0,
    output logic       rej1,
    output logic       ocupado,
    output logic [1:0] dono,
    output logic [2:0] perfil_ativo,
    output logic [2:0] func_ativa,
    output logic       fim,
    output logic       preempcao
);

    localparam logic [1:0] LIVRE   = 2'd0;
    localparam logic [1:0] EXECUTA = 2'd1;
    localparam logic [1:0] LIBERA  = 2'd2;

    localparam logic [7:0] TEMPO_LIM = 8'(TEMPO_EXEC);

    logic [1:0] estado;
    logic [7:0] contador;
    logic       ultimo;      // channel granted most recently
    logic       armado0;
    logic       armado1;

    logic       cons0, cons1;
    logic       valido0, valido1;
    logic       cand0, cand1;
    logic       vence1;
    logic       preempta;

    always_comb begin
        cons0   = armado0 & req0;
        cons1   = armado1 & req1;
        valido0 = (perfil0 >= 3'd1) && (perfil0 <= 3'd5) && (funcao0 != 3'd0);
        valido1 = (perfil1 >= 3'd1) && (perfil1 <= 3'd5) && (funcao1 != 3'd0);
        cand0   = cons0 & valido0;
        cand1   = cons1 & valido1;

        // Channel 1 wins when alone, when it out-ranks channel 0, or on a tie
        // when channel 0 was the last one served.
        vence1 = 1'b0;
        if (cand1 && !cand0) begin
            vence1 = 1'b1;
        end else if (cand0 && cand1) begin
            if (perfil1 > perfil0) begin
                vence1 = 1'b1;
            end else if (perfil1 == perfil0) begin
                vence1 = ~ultimo;
            end
        end

        // dono is non-zero only while a window is executing.
        preempta = 1'b0;
        if (dono == 2'b01) begin
            preempta = cand1 && (perfil1 > perfil_ativo);
        end else if (dono == 2'b10) begin
            preempta = cand0 && (perfil0 > perfil_ativo);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado       <= LIVRE;
            contador     <= '0;
            ultimo       <= 1'b1;
            armado0      <= 1'b1;
            armado1      <= 1'b1;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            rej0         <= 1'b0;
            rej1         <= 1'b0;
            ocupado      <= 1'b0;
            dono         <= '0;
            perfil_ativo <= '0;
            func_ativa   <= '0;
            fim          <= 1'b0;
            preempcao    <= 1'b0;
        end else begin
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rej0      <= 1'b0;
            rej1      <= 1'b0;
            fim       <= 1'b0;
            preempcao <= 1'b0;

            // Re-arm once the request is seen low; an ack/rej below can only
            // happen with req high, so the two updates never collide.
            if (!req0) armado0 <= 1'b1;
            if (!req1) armado1 <= 1'b1;

            case (estado)
                LIVRE: begin
                    if (cons0 && !valido0) begin
                        rej0    <= 1'b1;
                        armado0 <= 1'b0;
                    end
                    if (cons1 && !valido1) begin
                        rej1    <= 1'b1;
                        armado1 <= 1'b0;
                    end
                    if (cand0 || cand1) begin
                        estado   <= EXECUTA;
                        ocupado  <= 1'b1;
                        contador <= 8'd1;
                        ultimo   <= vence1;
                        if (vence1) begin
                            ack1         <= 1'b1;
                            armado1      <= 1'b0;
                            dono         <= 2'b10;
                            perfil_ativo <= perfil1;
                            func_ativa   <= funcao1;
                        end else begin
                            ack0         <= 1'b1;
                            armado0      <= 1'b0;
                            dono         <= 2'b01;
                            perfil_ativo <= perfil0;
                            func_ativa   <= funcao0;
                        end
                    end
                end

                EXECUTA: begin
                    if (preempta || (contador == TEMPO_LIM)) begin
                        estado       <= LIBERA;
                        fim          <= 1'b1;
                        preempcao    <= preempta;
                        ocupado      <= 1'b0;
                        dono         <= '0;
                        perfil_ativo <= '0;
                        func_ativa   <= '0;
                        contador     <= '0;
                    end else begin
                        contador <= contador + 8'd1;
                    end
                end

                LIBERA: begin
                    estado <= LIVRE;
                end

                default: begin
                    estado <= LIVRE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_escalonador_interfaces.sv
// ---------------------------------------------------------------------------
// tb_escalonador_interfaces
//   Self-checking bench for escalonador_interfaces: a table of single-edge
//   arbitration vectors from reset, hand-written multi-cycle sequences, and a
//   randomized run compared against a timestamp-based reference model.
// ---------------------------------------------------------------------------
module tb_escalonador_interfaces;

    localparam int TEMPO = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [2:0] perfil0, perfil1, funcao0, funcao1;
    logic       ack0, ack1, rej0, rej1, ocupado, fim, preempcao;
    logic [1:0] dono;
    logic [2:0] perfil_ativo, func_ativa;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    escalonador_interfaces #(.TEMPO_EXEC(TEMPO)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .perfil0(perfil0), .perfil1(perfil1),
        .funcao0(funcao0), .funcao1(funcao1),
        .ack0(ack0), .ack1(ack1), .rej0(rej0), .rej1(rej1),
        .ocupado(ocupado), .dono(dono),
        .perfil_ativo(perfil_ativo), .func_ativa(func_ativa),
        .fim(fim), .preempcao(preempcao)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (time-stamp based) ----------------
    int       m_owner;       // -1 none, else channel index
    int       m_last;        // last granted channel
    int       m_grant_cyc;   // cycle in which the ack was visible
    int       m_fim_cyc;     // cycle in which fim was visible
    bit       m_armed [2];
    bit [1:0] e_ack, e_rej;
    bit       e_fim, e_pre, e_ocup;
    int       e_dono, e_perf, e_func;

    function automatic logic [15:0] mk(logic a0, logic a1, logic j0, logic j1, logic oc,
                                       int dn, int pa, int fa, logic fm, logic pr);
        logic [1:0] d;
        logic [2:0] p, f;
        d = dn[1:0];
        p = pa[2:0];
        f = fa[2:0];
        return {1'b0, a0, a1, j0, j1, oc, d, p, f, fm, pr};
    endfunction

    function automatic logic [15:0] dut_pack();
        return mk(ack0, ack1, rej0, rej1, ocupado, int'(dono), int'(perfil_ativo),
                  int'(func_ativa), fim, preempcao);
    endfunction

    function automatic logic [15:0] model_pack();
        return mk(e_ack[0], e_ack[1], e_rej[0], e_rej[1], e_ocup, e_dono, e_perf,
                  e_func, e_fim, e_pre);
    endfunction

    function automatic bit is_valid(int p, int f);
        return (p >= 1) && (p <= 5) && (f != 0);
    endfunction

    task automatic model_reset();
        m_owner    = -1;
        m_last     = 1;
        m_grant_cyc = cyc - 100;
        m_fim_cyc  = cyc - 100;
        m_armed[0] = 1'b1;
        m_armed[1] = 1'b1;
        e_ack = '0; e_rej = '0; e_fim = 0; e_pre = 0; e_ocup = 0;
        e_dono = 0; e_perf = 0; e_func = 0;
    endtask

    // Predicts the outputs visible in cycle 'cyc' from inputs sampled at its edge.
    task automatic model_step();
        bit rq [2];
        int pf [2];
        int fn [2];
        bit cons [2];
        bit ok [2];
        bit arm_next [2];
        int cand [$];
        int o, w;
        bit pre;
        rq[0] = req0;  pf[0] = int'(perfil0); fn[0] = int'(funcao0);
        rq[1] = req1;  pf[1] = int'(perfil1); fn[1] = int'(funcao1);
        for (int i = 0; i < 2; i++) begin
            cons[i]     = m_armed[i] && rq[i];
            ok[i]       = is_valid(pf[i], fn[i]);
            arm_next[i] = rq[i] ? m_armed[i] : 1'b1;
        end
        e_ack = '0; e_rej = '0; e_fim = 0; e_pre = 0;
        if (m_owner >= 0) begin
            o   = 1 - m_owner;
            pre = cons[o] && ok[o] && (pf[o] > e_perf);
            if (pre || (cyc == m_grant_cyc + TEMPO)) begin
                e_fim = 1; e_pre = pre; e_ocup = 0;
                e_dono = 0; e_perf = 0; e_func = 0;
                m_owner   = -1;
                m_fim_cyc = cyc;
            end
        end else if (cyc >= m_fim_cyc + 2) begin
            for (int i = 0; i < 2; i++) begin
                if (cons[i]) begin
                    if (ok[i]) cand.push_back(i);
                    else begin
                        e_rej[i]    = 1'b1;
                        arm_next[i] = 1'b0;
                    end
                end
            end
            if (cand.size() > 0) begin
                w = cand[0];
                if (cand.size() == 2) begin
                    if (pf[1] > pf[0])      w = 1;
                    else if (pf[0] > pf[1]) w = 0;
                    else                    w = 1 - m_last;
                end
                m_owner     = w;
                m_last      = w;
                m_grant_cyc = cyc;
                e_ack[w]    = 1'b1;
                arm_next[w] = 1'b0;
                e_ocup = 1; e_dono = w + 1; e_perf = pf[w]; e_func = fn[w];
            end
        end
        m_armed = arm_next;
    endtask

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        cyc++;
        if (rst) model_reset();
        else     model_step();
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r0, input logic [2:0] p0, input logic [2:0] f0,
                         input logic r1, input logic [2:0] p1, input logic [2:0] f1);
        req0 = r0; perfil0 = p0; funcao0 = f0;
        req1 = r1; perfil1 = p1; funcao1 = f1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic       r0;
        logic [2:0] p0, f0;
        logic       r1;
        logic [2:0] p1, f1;
        logic [15:0] exp;
    } vec_t;

    vec_t tab [12];
    int   n, got;
    bit   seen;
    int   exp_grant [3];

    initial begin
        // {req0,perfil0,funcao0, req1,perfil1,funcao1} -> outputs after one edge from reset
        tab[0]  = '{1, 3, 2, 0, 0, 0, mk(1, 0, 0, 0, 1, 1, 3, 2, 0, 0)};
        tab[1]  = '{0, 0, 0, 1, 6, 1, mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0)};
        tab[2]  = '{1, 2, 1, 1, 4, 5, mk(0, 1, 0, 0, 1, 2, 4, 5, 0, 0)};
        tab[3]  = '{1, 3, 1, 1, 3, 4, mk(1, 0, 0, 0, 1, 1, 3, 1, 0, 0)};
        tab[4]  = '{1, 0, 1, 1, 1, 1, mk(0, 1, 1, 0, 1, 2, 1, 1, 0, 0)};
        tab[5]  = '{1, 5, 0, 0, 0, 0, mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0)};
        tab[6]  = '{1, 7, 3, 1, 7, 3, mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0)};
        tab[7]  = '{0, 5, 5, 0, 5, 5, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tab[8]  = '{1, 5, 7, 1, 5, 7, mk(1, 0, 0, 0, 1, 1, 5, 7, 0, 0)};
        tab[9]  = '{1, 1, 1, 1, 2, 3, mk(0, 1, 0, 0, 1, 2, 2, 3, 0, 0)};
        tab[10] = '{1, 5, 1, 1, 0, 0, mk(1, 0, 0, 1, 1, 1, 5, 1, 0, 0)};
        tab[11] = '{1, 4, 6, 1, 5, 0, mk(1, 0, 0, 1, 1, 1, 4, 6, 0, 0)};

        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        do_reset();
        check("reset_state", dut_pack(), 16'h0000);

        for (int i = 0; i < 12; i++) begin
            do_reset();
            drive(tab[i].r0, tab[i].p0, tab[i].f0, tab[i].r1, tab[i].p1, tab[i].f1);
            tick();
            check($sformatf("vec[%0d]", i), dut_pack(), tab[i].exp);
        end

        // Single grant: window of TEMPO cycles then one fim cycle.
        do_reset();
        drive(1, 3, 2, 0, 0, 0);
        tick();
        check("w_ack", dut_pack(), mk(1, 0, 0, 0, 1, 1, 3, 2, 0, 0));
        drive(0, 3, 2, 0, 0, 0);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!ocupado) break;
            n++;
        end
        check("w_len", 16'(n), 16'(TEMPO));
        check("w_fim", dut_pack(), mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tick();
        check("w_after", dut_pack(), 16'h0000);

        // Higher profile wins; loser served two cycles after fim.
        do_reset();
        drive(1, 2, 1, 1, 4, 5);
        tick();
        check("pri_ack1", dut_pack(), mk(0, 1, 0, 0, 1, 2, 4, 5, 0, 0));
        drive(1, 2, 1, 0, 4, 5);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fim) begin seen = 1; break; end
        end
        check("pri_fim_seen", 16'(seen), 16'd1);
        tick();
        check("pri_gap", 16'(ack0), 16'd0);
        tick();
        check("pri_ack0", dut_pack(), mk(1, 0, 0, 0, 1, 1, 2, 1, 0, 0));

        // Equal profiles alternate 0,1,0.
        do_reset();
        exp_grant[0] = 0; exp_grant[1] = 1; exp_grant[2] = 0;
        drive(1, 3, 1, 1, 3, 1);
        for (int k = 0; k < 3; k++) begin
            seen = 0;
            for (int i = 0; i < 30; i++) begin
                tick();
                if (ack0 || ack1) begin seen = 1; break; end
            end
            got = ack1 ? 1 : 0;
            check($sformatf("rr_seen[%0d]", k), 16'(seen), 16'd1);
            check($sformatf("rr_grant[%0d]", k), 16'(got), 16'(exp_grant[k]));
            if (got == 0) req0 = 1'b0; else req1 = 1'b0;
            tick();
            req0 = 1'b1; req1 = 1'b1;
        end

        // Invalid request rejected once until the request is dropped.
        do_reset();
        drive(0, 0, 0, 1, 6, 1);
        tick();
        check("rej_first", dut_pack(), mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        n = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rej1) n++;
        end
        check("rej_held", 16'(n), 16'd0);
        req1 = 1'b0;
        tick();
        req1 = 1'b1;
        tick();
        check("rej_again", 16'(rej1), 16'd1);

        // Preemption at counter 3.
        do_reset();
        drive(1, 2, 1, 0, 0, 0);
        tick();
        check("pre_ack0", dut_pack(), mk(1, 0, 0, 0, 1, 1, 2, 1, 0, 0));
        tick();
        tick();
        drive(1, 2, 1, 1, 5, 1);
        tick();
        check("pre_fim", dut_pack(), mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        tick();
        check("pre_gap", dut_pack(), 16'h0000);
        tick();
        check("pre_ack1", dut_pack(), mk(0, 1, 0, 0, 1, 2, 5, 1, 0, 0));

        // Asynchronous reset mid-window, then normal service.
        do_reset();
        drive(1, 3, 2, 0, 0, 0);
        tick();
        tick(); tick(); tick();
        check("ar_busy", 16'(ocupado), 16'd1);
        req0 = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("ar_immediate", dut_pack(), 16'h0000);
        tick();
        check("ar_nofim", dut_pack(), 16'h0000);
        rst = 1'b0;
        drive(1, 1, 1, 0, 0, 0);
        tick();
        check("ar_ack", dut_pack(), mk(1, 0, 0, 0, 1, 1, 1, 1, 0, 0));

        // Randomized run against the reference model.
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
                check($sformatf("rand_rst[%0d]", k), dut_pack(), model_pack());
                continue;
            end
            if ($urandom_range(0, 2) == 0) begin
                req0    = ($urandom_range(0, 3) != 0);
                perfil0 = 3'($urandom_range(0, 7));
                funcao0 = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 2) == 0) begin
                req1    = ($urandom_range(0, 3) != 0);
                perfil1 = 3'($urandom_range(0, 7));
                funcao1 = 3'($urandom_range(0, 7));
            end
            tick();
            check($sformatf("rand[%0d]", k), dut_pack(), model_pack());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/escalonador_interfaces.md
ESCALONADOR_INTERFACES -- requirements
Module: escalonador_interfaces

Interface
REQ-001 Parameter: TEMPO_EXEC, default 8, execution-window length in clock cycles (legal range 2..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0, req1  input  1 each  request level from interface 0 / interface 1.
REQ-005 perfil0, perfil1  input  3 each  requester profile code.
REQ-006 funcao0, funcao1  input  3 each  requested function code.
REQ-007 ack0, ack1  output  1 each  one-cycle grant pulse.
REQ-008 rej0, rej1  output  1 each  one-cycle rejection pulse.
REQ-009 ocupado  output  1  shared display/matrix resource in use.
REQ-010 dono  output  2  owner: 00 none, 01 interface 0, 10 interface 1; 11 never driven.
REQ-011 perfil_ativo, func_ativa  output  3 each  latched profile/function of owner.
REQ-012 fim  output  1  one-cycle end-of-window pulse.
REQ-013 preempcao  output  1  one-cycle pulse marking a preempted window.

Function
REQ-014 Request valid iff perfil in 1..5 and funcao != 0; perfil 0, 6, 7 invalid.
REQ-015 Per-channel "armado" flag: channel considered only when armado=1 and req=1; armado cleared on that channel's ack or rej, set again after req sampled low.
REQ-016 States: LIVRE, EXECUTA, LIBERA; all outputs registered.
REQ-017 LIVRE, edge with considered invalid request: rej pulse on that channel the following cycle; state stays LIVRE.
REQ-018 LIVRE, edge with one considered valid request: next cycle ack=1 on that channel, ocupado=1, dono/perfil_ativo/func_ativa latched, counter=1, state EXECUTA.
REQ-019 Both considered and valid: higher perfil wins; equal perfil: round-robin pointer picks channel not granted last; loser gets no ack/rej and keeps armado=1.
REQ-020 One valid, one invalid on same edge: valid one granted, invalid one rejected, both pulses same cycle.
REQ-021 EXECUTA: outputs held stable; counter increments each cycle; at counter=TEMPO_EXEC go LIBERA (window exactly TEMPO_EXEC cycles, ack cycle included).
REQ-022 Preemption: in EXECUTA, if non-owner channel is considered, valid, and perfil strictly greater than perfil_ativo, go LIBERA next edge with preempcao=1; preempting channel stays armado, not acked.
REQ-023 LIBERA lasts 1 cycle: fim=1, ocupado=0, dono=00, perfil_ativo=func_ativa=0; then LIVRE; earliest next ack is 2 cycles after fim.
REQ-024 Round-robin pointer updates only on ack, to the granted channel.
REQ-025 Non-owner invalid requests during EXECUTA/LIBERA are not rejected until LIVRE.
REQ-026 ack0&ack1, or fim with ocupado=1, never asserted.

Reset
REQ-027 rst=1 forces immediately: state LIVRE, all outputs 0, counter 0, pointer favouring channel 0, both armado=1.
REQ-028 rst mid-EXECUTA aborts without fim or preempcao pulse.

Verification
REQ-029 req0=1, perfil0=3, funcao0=2 -> ack0 next cycle, dono=01, func_ativa=2, ocupado 8 cycles, then fim=1 for 1 cycle.
REQ-030 Same edge req0 (perfil 2, funcao 1) and req1 (perfil 4, funcao 5) -> ack1, dono=10; after fim, req0 still high -> ack0 2 cycles after fim.
REQ-031 Both perfil 3, valid, held through three windows -> grants 0,1,0.
REQ-032 req1=1, perfil1=6 -> rej1 once; req1 held high -> no further rej1; drop one cycle and reassert -> rej1 again.
REQ-033 Owner 0 perfil 2 at counter=3, req1 perfil 5 funcao 1 -> next cycle fim=1, preempcao=1; then ack1.
REQ-034 rst pulsed during EXECUTA counter=4 -> outputs 0 at once, no fim; valid req after release -> ack normally.
